cache_mem_subsystem: RTL and testbench

CACHE_MEM_SUBSYSTEM -- requirements
Module: cache_mem_subsystem

---
 rtl/cache_mem_subsystem_if.sv | 22 ++
 rtl/cache_mem_subsystem.sv | 195 +++++++++++++++++++
 tb/tb_cache_mem_subsystem.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cache_mem_subsystem_if.sv
// CPU-side request/response bus for the cache memory subsystem.
interface cache_mem_subsystem_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) ();
  logic [ADDR_W-1:0] address;
  logic              c_read_i;
  logic              c_wr_i;
  logic [WORD_W-1:0] c_write_data_i;
  logic [WORD_W-1:0] c_data_o;
  logic              c_busywait_o;

  modport master (
    output address, c_read_i, c_wr_i, c_write_data_i,
    input  c_data_o, c_busywait_o
  );

  modport slave (
    input  address, c_read_i, c_wr_i, c_write_data_i,
    output c_data_o, c_busywait_o
  );
endinterface

// File: rtl/cache_mem_subsystem.sv
// Set-associative write-back, write-allocate cache with true-LRU replacement,
// coupled to a fixed-latency block memory.
module cache_mem_subsystem #(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 1,
  parameter int WAYS     = 4,
  parameter int MEM_LAT  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  cache_mem_subsystem_if.slave  cpu
);
  localparam int WPB        = 1 << OFFSET_W;
  localparam int BLOCK_W    = WORD_W * WPB;
  localparam int SETS       = 1 << INDEX_W;
  localparam int TAG_W      = ADDR_W - 2 - OFFSET_W - INDEX_W;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int MEM_BLOCKS = 64;
  localparam int CNT_W      = 8;
  localparam int CNT_INIT   = (MEM_LAT > 3) ? MEM_LAT - 3 : 0;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  state_t state, next_state;

  logic [WAYS-1:0]    line_valid [SETS];
  logic [WAYS-1:0]    line_dirty [SETS];
  logic [WAY_W-1:0]   line_age   [SETS][WAYS];
  logic [TAG_W-1:0]   line_tag   [SETS][WAYS];
  logic [BLOCK_W-1:0] line_data  [SETS][WAYS];

  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] word_sel;
  logic [TAG_W-1:0]    tag;
  logic                req, hit;
  logic [WAY_W-1:0]    hit_way, victim, touch_way, ref_age;
  logic                touch;

  logic               mem_read, mem_write;
  logic [5:0]         mem_addr;
  logic [BLOCK_W-1:0] mem_wdata, mem_rdata;
  logic               read_done, write_done;

  assign idx      = cpu.address[2+OFFSET_W +: INDEX_W];
  assign word_sel = cpu.address[2 +: OFFSET_W];
  assign tag      = cpu.address[ADDR_W-1 -: TAG_W];
  assign req      = cpu.c_read_i | cpu.c_wr_i;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (line_valid[idx][w] && line_tag[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Oldest way first, then overridden by the lowest-numbered invalid way.
  always_comb begin
    victim = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (line_valid[idx][w] && line_age[idx][w] == WAY_W'(WAYS - 1))
        victim = WAY_W'(w);
    end
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!line_valid[idx][w-1])
        victim = WAY_W'(w - 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:
        if (req && !hit)
          next_state = (line_valid[idx][victim] && line_dirty[idx][victim]) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (write_done) next_state = ALLOCATE;
      ALLOCATE:  if (read_done)  next_state = UPDATE;
      UPDATE:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_addr         = 6'(cpu.address[ADDR_W-1:OFFSET_W+2]);
    mem_wdata        = line_data[idx][victim];
    cpu.c_busywait_o = 1'b1;
    cpu.c_data_o     = hit ? line_data[idx][hit_way][int'(word_sel)*WORD_W +: WORD_W] : '0;
    case (state)
      IDLE:      cpu.c_busywait_o = req && !hit;
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = 6'({line_tag[idx][victim], idx});
      end
      ALLOCATE:  mem_read = 1'b1;
      default:   ;
    endcase
  end

  // A freshly filled invalid way counts as oldest so every valid way ages past it.
  assign touch     = (state == UPDATE) || (state == IDLE && req && hit);
  assign touch_way = (state == UPDATE) ? victim : hit_way;
  assign ref_age   = line_valid[idx][touch_way] ? line_age[idx][touch_way] : WAY_W'(WAYS - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        line_valid[s] <= '0;
        line_dirty[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) line_age[s][w] <= '0;
      end
    end else begin
      if (touch) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way)
            line_age[idx][w] <= '0;
          else if (line_valid[idx][w] && line_age[idx][w] < ref_age)
            line_age[idx][w] <= line_age[idx][w] + WAY_W'(1);
        end
      end
      if (state == UPDATE) begin
        line_valid[idx][victim] <= 1'b1;
        line_dirty[idx][victim] <= 1'b0;
      end else if (state == IDLE && cpu.c_wr_i && hit) begin
        line_dirty[idx][hit_way] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == UPDATE) begin
      line_tag[idx][victim]  <= tag;
      line_data[idx][victim] <= mem_rdata;
    end else if (state == IDLE && cpu.c_wr_i && hit) begin
      line_data[idx][hit_way][int'(word_sel)*WORD_W +: WORD_W] <= cpu.c_write_data_i;
    end
  end

  // Backing memory: busy holds one recovery cycle after the done pulse.
  logic [BLOCK_W-1:0] mem_blocks [MEM_BLOCKS];
  logic               mem_busy, mem_done, mem_drain, mem_op_write;
  logic [5:0]         mem_ptr;
  logic [BLOCK_W-1:0] mem_wbuf;
  logic [CNT_W-1:0]   mem_cnt;

  assign read_done  = mem_done && !mem_op_write;
  assign write_done = mem_done && mem_op_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_busy     <= 1'b0;
      mem_done     <= 1'b0;
      mem_drain    <= 1'b0;
      mem_op_write <= 1'b0;
      mem_ptr      <= '0;
      mem_cnt      <= '0;
      mem_wbuf     <= '0;
      mem_rdata    <= '0;
      for (int unsigned b = 0; b < MEM_BLOCKS; b++)
        for (int unsigned j = 0; j < WPB; j++)
          mem_blocks[b][j*WORD_W +: WORD_W] <= WORD_W'(b * WPB + j);
    end else if (!mem_busy) begin
      if (mem_read || mem_write) begin
        mem_busy     <= 1'b1;
        mem_op_write <= mem_write;
        mem_ptr      <= mem_addr;
        mem_wbuf     <= mem_wdata;
        mem_cnt      <= CNT_W'(CNT_INIT);
      end
    end else if (mem_done) begin
      mem_done  <= 1'b0;
      mem_drain <= 1'b1;
    end else if (mem_drain) begin
      mem_drain <= 1'b0;
      mem_busy  <= 1'b0;
    end else if (mem_cnt == '0) begin
      mem_done <= 1'b1;
      if (mem_op_write) mem_blocks[mem_ptr] <= mem_wbuf;
      else              mem_rdata <= mem_blocks[mem_ptr];
    end else begin
      mem_cnt <= mem_cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cache_mem_subsystem.sv
// Table-driven scoreboard bench for cache_mem_subsystem with hand-written reset/abort sequences.
module tb_cache_mem_subsystem;
  localparam int STALL_MAX = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_mem_subsystem_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  cache_mem_subsystem #(
    .ADDR_W(32), .WORD_W(32), .OFFSET_W(2), .INDEX_W(1), .WAYS(4), .MEM_LAT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cpu   (bus)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_stall;
    logic        chk_mem;
    int          mem_blk;
    int          mem_word;
    logic [31:0] mem_exp;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_data, input int exp_stall,
                              input logic chk_mem, input int blk, input int word,
                              input logic [31:0] mem_exp);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_stall = exp_stall;
    v.chk_mem = chk_mem; v.mem_blk = blk; v.mem_word = word; v.mem_exp = mem_exp;
    return v;
  endfunction

  task automatic idle_bus();
    bus.c_read_i       = 1'b0;
    bus.c_wr_i         = 1'b0;
    bus.c_write_data_i = '0;
  endtask

  task automatic run_op(input vec_t v);
    vec_t           e;
    int             stall;
    logic [31:0]    got;
    logic [127:0]   blk;
    exp_q.push_back(v);
    @(negedge clk);
    bus.address        = v.addr;
    bus.c_read_i       = v.rd;
    bus.c_wr_i         = v.wr;
    bus.c_write_data_i = v.wdata;
    #1;
    stall = 0;
    while (bus.c_busywait_o && stall < STALL_MAX) begin
      @(negedge clk);
      #1;
      stall++;
    end
    got = bus.c_data_o;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = exp_q.pop_front();
      check({e.name, " stall"}, 32'(stall), 32'(e.exp_stall));
      if (e.rd && !e.wr) check({e.name, " data"}, got, e.exp_data);
      @(posedge clk);
      #1;
      idle_bus();
      if (e.chk_mem) begin
        blk = dut.mem_blocks[e.mem_blk];
        check({e.name, " mem"}, blk[e.mem_word*32 +: 32], e.mem_exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.address = 32'h0E;
    idle_bus();
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, bus.c_busywait_o}, 32'h0);
    check("reset data", bus.c_data_o, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle busy", {31'b0, bus.c_busywait_o}, 32'h0);
    check("idle data", bus.c_data_o, 32'h0);

    vecs.push_back(mk("cold rd 0E",   1, 0, 32'h0E, 0,      32'h3,   6,  0, 0, 0, 0));
    vecs.push_back(mk("hit rd 0A",    1, 0, 32'h0A, 0,      32'h2,   0,  0, 0, 0, 0));
    vecs.push_back(mk("miss rd 16",   1, 0, 32'h16, 0,      32'h5,   6,  0, 0, 0, 0));
    vecs.push_back(mk("hit wr 1A",    0, 1, 32'h1A, 32'h38, 0,       0,  0, 0, 0, 0));
    vecs.push_back(mk("rd 1A",        1, 0, 32'h1A, 0,      32'h38,  0,  1, 1, 2, 32'h6));
    vecs.push_back(mk("wr miss 3A",   0, 1, 32'h3A, 32'h100, 0,      6,  0, 0, 0, 0));
    vecs.push_back(mk("wr miss 5A",   0, 1, 32'h5A, 32'h200, 0,      6,  0, 0, 0, 0));
    vecs.push_back(mk("wr miss 7A",   0, 1, 32'h7A, 32'h300, 0,      6,  0, 0, 0, 0));
    vecs.push_back(mk("dirty rd 9A",  1, 0, 32'h9A, 0,      32'h26,  11, 1, 1, 2, 32'h38));
    vecs.push_back(mk("hit rd 5A",    1, 0, 32'h5A, 0,      32'h200, 0,  0, 0, 0, 0));
    vecs.push_back(mk("dirty rd 1A",  1, 0, 32'h1A, 0,      32'h38,  11, 1, 3, 2, 32'h100));
    vecs.push_back(mk("dirty rd 3A",  1, 0, 32'h3A, 0,      32'h100, 11, 1, 7, 2, 32'h300));
    vecs.push_back(mk("set0 rd 0E",   1, 0, 32'h0E, 0,      32'h3,   0,  0, 0, 0, 0));
    vecs.push_back(mk("rdwr 0E",      1, 1, 32'h0E, 32'hABCD, 0,     0,  0, 0, 0, 0));
    vecs.push_back(mk("rd back 0E",   1, 0, 32'h0E, 0,      32'hABCD, 0, 1, 0, 3, 32'h3));

    foreach (vecs[i]) run_op(vecs[i]);

    // Abort a clean miss while the memory read is in flight.
    @(negedge clk);
    bus.address  = 32'h4E;
    bus.c_read_i = 1'b1;
    repeat (2) @(negedge clk);
    check("alloc busy", {31'b0, bus.c_busywait_o}, 32'h1);
    reset        = 1'b1;
    bus.c_read_i = 1'b0;
    bus.address  = 32'h0E;
    #1;
    check("abort busy", {31'b0, bus.c_busywait_o}, 32'h0);
    check("abort data", bus.c_data_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op(mk("re-miss 0E", 1, 0, 32'h0E, 0, 32'h3,  6, 0, 0, 0, 0));
    run_op(mk("re-miss 4E", 1, 0, 32'h4E, 0, 32'h13, 6, 0, 0, 0, 0));

    check("scoreboard drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
